seq_mult_signed: RTL and testbench

- Parametrised sequential add-shift multiplier. Operand widths are WIDTH, and the product is 2*WIDTH bits.
- Supports signed (two's-complement) and unsigned modes.
- Has an internal control FSM and a Start/Done handshake.
- Chained multiplication works: the previous low half of the product stays in B as the next multiplier.
- Sits between the switch/operand input and the hex-display/result path of the lab datapath.

---
 rtl/seq_mult_signed.sv | 172 +++++++++++++++++
 tb/tb_seq_mult_signed.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed.sv
// seq_mult_signed: sequential add-shift multiplier, signed or unsigned.
// The product accumulates in {X, A, B}; B starts as the multiplier and ends
// as the low product half, so a following Start chains the multiplication.
module seq_mult_signed #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Load_B,
    input  logic             Clear_A,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sub_s;
    logic [WIDTH:0]   sum_s;

    // One WIDTH+1-bit add (or subtract via inverted operand and carry-in);
    // the extra bit keeps -2^(W-1) * -2^(W-1) from overflowing.
    function automatic logic [WIDTH:0] add_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] m,
        input logic             sgn,
        input logic             sub
    );
        logic [WIDTH:0] ea;
        logic [WIDTH:0] em;
        logic [WIDTH:0] res;
        ea = {sgn & a[WIDTH-1], a};
        em = {sgn & m[WIDTH-1], m};
        if (sub) begin
            res = ea + ~em + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            res = ea + em;
        end
        return res;
    endfunction

    // The multiplier MSB carries negative weight in signed mode, so the last
    // partial product is subtracted.
    always_comb begin
        sub_s = mode_q && (cnt_q == LAST_BIT);
        sum_s = add_sub(a_q, mcand_q, mode_q, sub_s);
    end

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_IDLE) && Start) begin
                    // Start wins over Load_B/Clear_A on this edge.
                    state_d = ST_ADD;
                    a_d     = {WIDTH{1'b0}};
                    x_d     = 1'b0;
                    mcand_d = S;
                    mode_d  = Signed_Mode;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    if (Load_B) begin
                        b_d = S;
                    end else begin
                        b_d = b_q;
                    end
                    if (Clear_A) begin
                        a_d = {WIDTH{1'b0}};
                        x_d = 1'b0;
                    end else begin
                        a_d = a_q;
                        x_d = x_q;
                    end
                    // DONE waits for Start to drop so a held Start cannot retrigger.
                    if ((state_q == ST_DONE) && !Start) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            ST_ADD: begin
                if (b_q[0]) begin
                    a_d = sum_s[WIDTH-1:0];
                    x_d = sum_s[WIDTH];
                end else begin
                    a_d = a_q;
                    x_d = x_q;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Arithmetic shift in signed mode; the unsigned carry shifts into A.
                x_d = mode_q ? x_q : 1'b0;
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = ST_ADD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ADD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; asynchronous reset discards any run.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            x_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_seq_mult_signed.sv
// Bench for seq_mult_signed: directed vectors at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected {X, product} into a queue; monitors pop and
// compare on each rising Done.
module tb_seq_mult_signed;

    logic        clk;
    logic        rst_n;

    logic        start8, load8, clear8, sgn8;
    logic [7:0]  s8;
    logic [7:0]  a8, b8;
    logic        x8, busy8, done8;

    logic        start16, load16, clear16, sgn16;
    logic [15:0] s16;
    logic [15:0] a16, b16;
    logic        x16, busy16, done16;

    int          checks;
    int          errors;
    logic [63:0] q8[$];
    logic [63:0] q16[$];
    logic        d8_prev;
    logic        d16_prev;

    seq_mult_signed #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset_n(rst_n), .Start(start8), .Load_B(load8),
        .Clear_A(clear8), .Signed_Mode(sgn8), .S(s8),
        .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
    );

    seq_mult_signed #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset_n(rst_n), .Start(start16), .Load_B(load16),
        .Clear_A(clear16), .Signed_Mode(sgn16), .S(s16),
        .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, WIDTH=8 instance.
    always @(negedge clk) begin
        if (rst_n && done8 && !d8_prev) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 64'd1, 64'd0);
            end else begin
                check("w8_product", {47'd0, x8, a8, b8}, q8.pop_front());
            end
        end
        d8_prev <= done8;
    end

    // Scoreboard monitor, WIDTH=16 instance.
    always @(negedge clk) begin
        if (rst_n && done16 && !d16_prev) begin
            if (q16.size() == 0) begin
                check("w16_unexpected_done", 64'd1, 64'd0);
            end else begin
                check("w16_product", {31'd0, x16, a16, b16}, q16.pop_front());
            end
        end
        d16_prev <= done16;
    end

    // One WIDTH=8 multiply: optional Load_B, Start, latency/Busy checks,
    // optional Start hold through DONE.
    task automatic run8(input string name, input logic sgn, input logic loadb,
                        input logic [7:0] b, input logic [7:0] s,
                        input logic [16:0] exp, input logic hold);
        int n;
        int nb;
        sgn8 = sgn;
        if (loadb) begin
            load8 = 1'b1;
            s8    = b;
            @(negedge clk);
            load8 = 1'b0;
        end
        q8.push_back({47'd0, exp});
        s8     = s;
        start8 = 1'b1;
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end while (!done8 && n < 40);
        check({name, "_latency"}, 64'(n), 64'd17);
        check({name, "_busy_cycles"}, 64'(nb), 64'd16);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                check({name, "_hold_no_rerun"}, {62'd0, done8, busy8}, 64'd2);
            end
        end
        start8 = 1'b0;
        @(negedge clk);
        check({name, "_back_idle"}, {62'd0, done8, busy8}, 64'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start8 = 1'b0; load8 = 1'b0; clear8 = 1'b0; sgn8 = 1'b0; s8 = 8'd0;
        start16 = 1'b0; load16 = 1'b0; clear16 = 1'b0; sgn16 = 1'b0; s16 = 16'd0;
        #1;
        check("reset_w8", {45'd0, a8, b8, x8, busy8, done8}, 64'd0);
        check("reset_w16", {29'd0, a16, b16, x16, busy16, done16}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 * 59 = 413, then chained 413 low byte (-99) * 2 = -198 with Start held.
        run8("s1", 1'b1, 1'b1, 8'h07, 8'h3B, {1'b0, 16'h019D}, 1'b0);
        run8("chain", 1'b1, 1'b0, 8'h00, 8'h02, {1'b1, 16'hFF3A}, 1'b1);

        // Clear_A in IDLE clears A and X but leaves B.
        clear8 = 1'b1;
        @(negedge clk);
        clear8 = 1'b0;
        check("clear_a", {47'd0, x8, a8, b8}, {47'd0, 1'b0, 8'h00, 8'h3A});

        run8("s2a", 1'b1, 1'b1, 8'h07, 8'hC5, {1'b1, 16'hFE63}, 1'b0);
        run8("s2b", 1'b1, 1'b1, 8'hC5, 8'h07, {1'b1, 16'hFE63}, 1'b0);
        run8("s2c", 1'b1, 1'b1, 8'h80, 8'h80, {1'b0, 16'h4000}, 1'b0);
        run8("s3u", 1'b0, 1'b1, 8'hFF, 8'hFF, {1'b0, 16'hFE01}, 1'b0);
        run8("s3s", 1'b1, 1'b1, 8'hFF, 8'hFF, {1'b0, 16'h0001}, 1'b0);

        // Reset mid-run: outputs clear without any clock edge.
        sgn8 = 1'b1;
        load8 = 1'b1;
        s8 = 8'h07;
        @(negedge clk);
        load8 = 1'b0;
        s8 = 8'h3B;
        start8 = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", {45'd0, a8, b8, x8, busy8, done8}, 64'd0);
        start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8("after_reset", 1'b1, 1'b1, 8'h07, 8'h3B, {1'b0, 16'h019D}, 1'b0);

        // WIDTH=16: -32768 * 32767, with Load_B pulsed mid-run.
        sgn16 = 1'b1;
        load16 = 1'b1;
        s16 = 16'h8000;
        @(negedge clk);
        load16 = 1'b0;
        q16.push_back({31'd0, 1'b1, 32'hC0008000});
        s16 = 16'h7FFF;
        start16 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 4) begin
                load16 = 1'b1;
                s16 = 16'h1234;
            end else begin
                load16 = 1'b0;
            end
        end while (!done16 && n < 80);
        check("w16_latency", 64'(n), 64'd33);
        start16 = 1'b0;
        @(negedge clk);
        check("w16_back_idle", {62'd0, done16, busy16}, 64'd0);

        check("scoreboard_drained", 64'(q8.size() + q16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
